// File: rtl/sram_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
package sram_pkg;

    localparam int          SRAM_DW       = 16;
    localparam int          SRAM_AW       = 18;
    localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/sram_phase_counter.sv
// Per-phase hold counter; tc marks the last cycle of a halfword phase.
module sram_phase_counter #(
    parameter int ACCESS_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       ld,
    input  logic [3:0] ld_val,
    input  logic       en,
    output logic       tc
);

    logic [3:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      cnt <= '0;
        else if (clr)  cnt <= '0;
        else if (ld)   cnt <= ld_val;
        else if (en)   cnt <= cnt + 4'd1;
    end

    assign tc = (cnt == 4'(ACCESS_CYCLES - 1));

endmodule

// File: rtl/sram_mem_controller.sv
// Splits 32-bit MEM-stage loads/stores into two halfword phases on a 16-bit
// asynchronous SRAM, holding the pipeline frozen via ready until done.
module sram_mem_controller
    import sram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = BASE_ADDR_DEF,
    parameter int          ACCESS_CYCLES = 2,
    parameter int          SRAM_AW       = sram_pkg::SRAM_AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [SRAM_DW-1:0] sram_dq_in,
    output logic               sram_we_n,
    output logic               sram_oe_n,
    output logic               sram_ce_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
);

    state_t             state_q, state_d;
    logic               op_wr_q;
    logic [SRAM_AW-2:0] word_q;
    logic [31:0]        wdata_q;
    logic [31:0]        offs;
    logic               start, cnt_clr, cnt_en, tc;
    logic               active, phase_hi;
    logic               unused_offs;

    assign offs        = address - BASE_ADDR;
    assign unused_offs = ^{offs[31:SRAM_AW+1], offs[1:0]};

    sram_phase_counter #(.ACCESS_CYCLES(ACCESS_CYCLES)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr),
        .ld     (start),
        .ld_val (4'd0),
        .en     (cnt_en),
        .tc     (tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            op_wr_q   <= 1'b0;
            word_q    <= '0;
            wdata_q   <= '0;
            read_data <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                op_wr_q <= wr_en;
                word_q  <= offs[SRAM_AW:2];
                wdata_q <= write_data;
            end
            // Read data is sampled on the last cycle of each phase
            if (state_q == LOW && tc && !op_wr_q)  read_data[15:0]  <= sram_dq_in;
            if (state_q == HIGH && tc && !op_wr_q) read_data[31:16] <= sram_dq_in;
        end
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            IDLE: if (rd_en || wr_en) begin
                start   = 1'b1;
                state_d = LOW;
            end
            LOW: begin
                cnt_en = 1'b1;
                if (tc) begin
                    cnt_clr = 1'b1;
                    state_d = HIGH;
                end
            end
            HIGH: begin
                cnt_en = 1'b1;
                if (tc) begin
                    cnt_clr = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign active   = (state_q == LOW) || (state_q == HIGH);
    assign phase_hi = (state_q == HIGH);

    always_comb begin
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        sram_oe_n   = 1'b1;
        if (active) begin
            sram_addr = {word_q, phase_hi};
            if (op_wr_q) begin
                sram_dq_out = phase_hi ? wdata_q[31:16] : wdata_q[15:0];
                sram_dq_oe  = 1'b1;
                sram_we_n   = 1'b0;
            end else begin
                sram_oe_n = 1'b0;
            end
        end
    end

    // Chip selects follow reset directly so the pads float while held in reset
    assign sram_ce_n = ~rst;
    assign sram_ub_n = ~rst;
    assign sram_lb_n = ~rst;

    assign ready = ~rst | ~(rd_en | wr_en) | (state_q == DONE);

endmodule
